// File: rtl/rv_rf_wb_sched.sv
`default_nettype none
// ============================================================================
//  Module   : rv_rf_wb_sched
//  Purpose  : Register-file write-port scheduler (pipeline / LSU / MDU) with a
//             long-latency write scoreboard and decode hazard stall.
//  Revision : 1.0 - initial release
// ============================================================================
module rv_rf_wb_sched #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        d_valid_i,
    input  logic [4:0]  d_rs1_i,
    input  logic [4:0]  d_rs2_i,
    input  logic [4:0]  d_rd_i,
    input  logic        d_long_i,
    output logic        d_stall_o,
    input  logic [4:0]  w_rd_i,
    input  logic [31:0] w_rd_value_i,
    input  logic        w_rd_store_i,
    output logic        w_stall_o,
    input  logic        lsu_valid_i,
    input  logic [4:0]  lsu_rd_i,
    input  logic [31:0] lsu_value_i,
    output logic        lsu_ready_o,
    input  logic        mdu_valid_i,
    input  logic [4:0]  mdu_rd_i,
    input  logic [31:0] mdu_value_i,
    output logic        mdu_ready_o,
    output logic [4:0]  rf_rd_o,
    output logic [31:0] rf_rd_value_o,
    output logic        rf_rd_store_o,
    output logic [31:0] pending_o
);

    localparam logic [3:0] c_starve_limit = STARVE_LIMIT[3:0];

    logic [31:0] r_pending;
    logic [3:0]  r_wait_cnt;
    logic        r_rr_mdu;      // 1: MDU has priority on the next contended grant
    logic [4:0]  r_rf_rd;
    logic [31:0] r_rf_value;
    logic        r_rf_store;

    logic        w_hazard;
    logic        w_any_req;
    logic        w_force;
    logic        w_pipe_win;
    logic        w_grant_lsu;
    logic        w_grant_mdu;
    logic        w_win_valid;
    logic [4:0]  w_win_rd;
    logic [31:0] w_win_value;
    logic [31:0] w_set_mask;
    logic [31:0] w_clr_mask;
    logic [31:0] w_pending_next;
    logic [3:0]  w_wait_next;

    // Hazard check against registered scoreboard
    always_comb begin
        w_hazard = d_valid_i &
                   (((d_rs1_i != 5'd0) & r_pending[d_rs1_i]) |
                    ((d_rs2_i != 5'd0) & r_pending[d_rs2_i]) |
                    ((d_rd_i  != 5'd0) & r_pending[d_rd_i]));
    end

    // Arbitration
    always_comb begin
        w_any_req   = lsu_valid_i | mdu_valid_i;
        w_force     = (r_wait_cnt == c_starve_limit) & w_any_req;
        w_pipe_win  = w_rd_store_i & ~w_force;
        w_grant_lsu = ~w_pipe_win & lsu_valid_i & (~mdu_valid_i | ~r_rr_mdu);
        w_grant_mdu = ~w_pipe_win & mdu_valid_i & (~lsu_valid_i |  r_rr_mdu);
    end

    always_comb begin
        w_win_valid = 1'b0;
        w_win_rd    = 5'd0;
        w_win_value = 32'd0;
        if (w_pipe_win) begin
            w_win_valid = 1'b1;
            w_win_rd    = w_rd_i;
            w_win_value = w_rd_value_i;
        end else if (w_grant_lsu) begin
            w_win_valid = 1'b1;
            w_win_rd    = lsu_rd_i;
            w_win_value = lsu_value_i;
        end else if (w_grant_mdu) begin
            w_win_valid = 1'b1;
            w_win_rd    = mdu_rd_i;
            w_win_value = mdu_value_i;
        end
    end

    // Scoreboard update: set beats clear on the same bit, x0 never tracked
    always_comb begin
        w_set_mask = 32'd0;
        w_clr_mask = 32'd0;
        if (d_valid_i & ~w_hazard & d_long_i & (d_rd_i != 5'd0)) begin
            w_set_mask[d_rd_i] = 1'b1;
        end
        if (w_grant_lsu) begin
            w_clr_mask[lsu_rd_i] = 1'b1;
        end
        if (w_grant_mdu) begin
            w_clr_mask[mdu_rd_i] = 1'b1;
        end
        w_pending_next = ((r_pending & ~w_clr_mask) | w_set_mask) & ~32'd1;
    end

    always_comb begin
        w_wait_next = r_wait_cnt;
        if (w_grant_lsu | w_grant_mdu | ~w_any_req) begin
            w_wait_next = 4'd0;
        end else if (w_pipe_win && (r_wait_cnt != c_starve_limit)) begin
            w_wait_next = r_wait_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_pending  <= 32'd0;
            r_wait_cnt <= 4'd0;
            r_rr_mdu   <= 1'b0;
            r_rf_rd    <= 5'd0;
            r_rf_value <= 32'd0;
            r_rf_store <= 1'b0;
        end else begin
            r_pending  <= w_pending_next;
            r_wait_cnt <= w_wait_next;
            if (w_grant_lsu) begin
                r_rr_mdu <= 1'b1;
            end else if (w_grant_mdu) begin
                r_rr_mdu <= 1'b0;
            end
            r_rf_store <= w_win_valid & (w_win_rd != 5'd0);
            if (w_win_valid) begin
                r_rf_rd    <= w_win_rd;
                r_rf_value <= w_win_value;
            end
        end
    end

    assign d_stall_o     = rst_n_i & w_hazard;
    assign w_stall_o     = rst_n_i & w_force & w_rd_store_i;
    assign lsu_ready_o   = rst_n_i & w_grant_lsu;
    assign mdu_ready_o   = rst_n_i & w_grant_mdu;
    assign rf_rd_o       = r_rf_rd;
    assign rf_rd_value_o = r_rf_value;
    assign rf_rd_store_o = r_rf_store;
    assign pending_o     = r_pending;

endmodule
`default_nettype wire

// File: tb/tb_rv_rf_wb_sched.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rv_rf_wb_sched
//  Purpose  : Scoreboard-based testbench for rv_rf_wb_sched.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rv_rf_wb_sched;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        d_valid_i;
    logic [4:0]  d_rs1_i, d_rs2_i, d_rd_i;
    logic        d_long_i;
    logic        d_stall_o;
    logic [4:0]  w_rd_i;
    logic [31:0] w_rd_value_i;
    logic        w_rd_store_i;
    logic        w_stall_o;
    logic        lsu_valid_i;
    logic [4:0]  lsu_rd_i;
    logic [31:0] lsu_value_i;
    logic        lsu_ready_o;
    logic        mdu_valid_i;
    logic [4:0]  mdu_rd_i;
    logic [31:0] mdu_value_i;
    logic        mdu_ready_o;
    logic [4:0]  rf_rd_o;
    logic [31:0] rf_rd_value_o;
    logic        rf_rd_store_o;
    logic [31:0] pending_o;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] value;
        logic        store;
    } wr_t;

    wr_t exp_q[$];
    wr_t exp;
    int  n_vec = 0;
    int  n_err = 0;

    rv_rf_wb_sched #(.STARVE_LIMIT(4)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .d_valid_i(d_valid_i), .d_rs1_i(d_rs1_i), .d_rs2_i(d_rs2_i),
        .d_rd_i(d_rd_i), .d_long_i(d_long_i), .d_stall_o(d_stall_o),
        .w_rd_i(w_rd_i), .w_rd_value_i(w_rd_value_i),
        .w_rd_store_i(w_rd_store_i), .w_stall_o(w_stall_o),
        .lsu_valid_i(lsu_valid_i), .lsu_rd_i(lsu_rd_i),
        .lsu_value_i(lsu_value_i), .lsu_ready_o(lsu_ready_o),
        .mdu_valid_i(mdu_valid_i), .mdu_rd_i(mdu_rd_i),
        .mdu_value_i(mdu_value_i), .mdu_ready_o(mdu_ready_o),
        .rf_rd_o(rf_rd_o), .rf_rd_value_o(rf_rd_value_o),
        .rf_rd_store_o(rf_rd_store_o), .pending_o(pending_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic drive_idle();
        d_valid_i = 0; d_rs1_i = 0; d_rs2_i = 0; d_rd_i = 0; d_long_i = 0;
        w_rd_i = 0; w_rd_value_i = 0; w_rd_store_i = 0;
        lsu_valid_i = 0; lsu_rd_i = 0; lsu_value_i = 0;
        mdu_valid_i = 0; mdu_rd_i = 0; mdu_value_i = 0;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        drive_idle();
        rst_n_i = 0;
        @(negedge clk_i);
        rst_n_i = 1;
    endtask

    task automatic test_reset();
        @(negedge clk_i);
        rst_n_i = 0;
        lsu_valid_i = 1; lsu_rd_i = 4; mdu_valid_i = 1; mdu_rd_i = 6;
        w_rd_store_i = 1; w_rd_i = 2; d_valid_i = 1; d_rs1_i = 1;
        #1;
        n_vec++;
        if ({lsu_ready_o, mdu_ready_o, w_stall_o, d_stall_o} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_outputs: got %b, want 0000",
                     {lsu_ready_o, mdu_ready_o, w_stall_o, d_stall_o});
        end
        @(posedge clk_i); #1;
        n_vec++;
        if ({pending_o, rf_rd_o, rf_rd_value_o, rf_rd_store_o} !== 70'd0) begin
            n_err++;
            $display("FAIL reset_state: got pend=%h rd=%0d val=%h st=%b, want all zero",
                     pending_o, rf_rd_o, rf_rd_value_o, rf_rd_store_o);
        end
        @(negedge clk_i);
        drive_idle();
        rst_n_i = 1;
    endtask

    task automatic test_hazard_lsu();
        @(negedge clk_i);
        d_valid_i = 1; d_rd_i = 5; d_long_i = 1;
        #1;
        n_vec++;
        if (d_stall_o !== 1'b0) begin
            n_err++; $display("FAIL issue_stall: got %b, want 0", d_stall_o);
        end
        @(posedge clk_i); #1;
        n_vec++;
        if (pending_o !== 32'h0000_0020) begin
            n_err++; $display("FAIL pending_set_x5: got %h, want 00000020", pending_o);
        end
        @(negedge clk_i);
        d_rd_i = 0; d_long_i = 0; d_rs1_i = 5;
        lsu_valid_i = 1; lsu_rd_i = 5; lsu_value_i = 32'hDEAD_BEEF;
        exp_q.push_back('{rd: 5'd5, value: 32'hDEAD_BEEF, store: 1'b1});
        #1;
        n_vec++;
        if ({d_stall_o, lsu_ready_o} !== 2'b11) begin
            n_err++;
            $display("FAIL raw_stall_lsu_ready: got stall=%b rdy=%b, want 1 1",
                     d_stall_o, lsu_ready_o);
        end
        @(posedge clk_i); #1;
        exp = exp_q.pop_front();
        n_vec++;
        if ({rf_rd_o, rf_rd_value_o, rf_rd_store_o} !== {exp.rd, exp.value, exp.store}) begin
            n_err++;
            $display("FAIL lsu_write: got rd=%0d val=%h st=%b, want rd=%0d val=%h st=%b",
                     rf_rd_o, rf_rd_value_o, rf_rd_store_o, exp.rd, exp.value, exp.store);
        end
        n_vec++;
        if ({pending_o, d_stall_o} !== 33'd0) begin
            n_err++;
            $display("FAIL lsu_clear: got pend=%h stall=%b, want 0 0", pending_o, d_stall_o);
        end
        @(negedge clk_i);
        drive_idle();
    endtask

    task automatic test_round_robin();
        int ln = 0;
        int mn = 0;
        logic want_lsu;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            lsu_valid_i = 1; lsu_rd_i = 5'(10 + ln); lsu_value_i = 32'h1000_0000 + ln;
            mdu_valid_i = 1; mdu_rd_i = 5'(20 + mn); mdu_value_i = 32'h2000_0000 + mn;
            want_lsu = (i % 2 == 0);
            if (want_lsu) exp_q.push_back('{rd: lsu_rd_i, value: lsu_value_i, store: 1'b1});
            else          exp_q.push_back('{rd: mdu_rd_i, value: mdu_value_i, store: 1'b1});
            #1;
            n_vec++;
            if ({lsu_ready_o, mdu_ready_o} !== {want_lsu, ~want_lsu}) begin
                n_err++;
                $display("FAIL rr_grant%0d: got lsu=%b mdu=%b, want lsu=%b mdu=%b",
                         i, lsu_ready_o, mdu_ready_o, want_lsu, ~want_lsu);
            end
            @(posedge clk_i); #1;
            exp = exp_q.pop_front();
            n_vec++;
            if ({rf_rd_o, rf_rd_value_o, rf_rd_store_o} !== {exp.rd, exp.value, exp.store}) begin
                n_err++;
                $display("FAIL rr_write%0d: got rd=%0d val=%h st=%b, want rd=%0d val=%h st=%b",
                         i, rf_rd_o, rf_rd_value_o, rf_rd_store_o, exp.rd, exp.value, exp.store);
            end
            if (want_lsu) ln++; else mn++;
        end
        @(negedge clk_i);
        drive_idle();
    endtask

    task automatic test_starvation();
        int wi;
        logic want_stall;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_i);
            wi = (i < 4) ? i : 4;
            w_rd_store_i = 1; w_rd_i = 5'(1 + wi); w_rd_value_i = 32'hA0 + wi;
            mdu_valid_i = (i <= 4); mdu_rd_i = 12; mdu_value_i = 32'h55;
            want_stall = (i == 4);
            if (want_stall) exp_q.push_back('{rd: 5'd12, value: 32'h55, store: 1'b1});
            else            exp_q.push_back('{rd: w_rd_i, value: w_rd_value_i, store: 1'b1});
            #1;
            n_vec++;
            if ({w_stall_o, mdu_ready_o} !== {want_stall, want_stall}) begin
                n_err++;
                $display("FAIL starve_cycle%0d: got wstall=%b mrdy=%b, want %b %b",
                         i, w_stall_o, mdu_ready_o, want_stall, want_stall);
            end
            @(posedge clk_i); #1;
            exp = exp_q.pop_front();
            n_vec++;
            if ({rf_rd_o, rf_rd_value_o, rf_rd_store_o} !== {exp.rd, exp.value, exp.store}) begin
                n_err++;
                $display("FAIL starve_write%0d: got rd=%0d val=%h st=%b, want rd=%0d val=%h st=%b",
                         i, rf_rd_o, rf_rd_value_o, rf_rd_store_o, exp.rd, exp.value, exp.store);
            end
        end
        @(negedge clk_i);
        drive_idle();
    endtask

    task automatic test_set_clear_conflict();
        @(negedge clk_i);
        d_valid_i = 1; d_rd_i = 7; d_long_i = 1;
        mdu_valid_i = 1; mdu_rd_i = 7; mdu_value_i = 32'h77;
        exp_q.push_back('{rd: 5'd7, value: 32'h77, store: 1'b1});
        #1;
        n_vec++;
        if ({d_stall_o, mdu_ready_o} !== 2'b01) begin
            n_err++;
            $display("FAIL conflict_handshake: got stall=%b mrdy=%b, want 0 1",
                     d_stall_o, mdu_ready_o);
        end
        @(posedge clk_i); #1;
        exp = exp_q.pop_front();
        n_vec++;
        if ({rf_rd_o, rf_rd_value_o, rf_rd_store_o} !== {exp.rd, exp.value, exp.store}) begin
            n_err++;
            $display("FAIL conflict_write: got rd=%0d val=%h st=%b, want rd=%0d val=%h st=%b",
                     rf_rd_o, rf_rd_value_o, rf_rd_store_o, exp.rd, exp.value, exp.store);
        end
        n_vec++;
        if (pending_o !== 32'h0000_0080) begin
            n_err++; $display("FAIL conflict_set_wins: got %h, want 00000080", pending_o);
        end
        @(negedge clk_i);
        drive_idle();
        lsu_valid_i = 1; lsu_rd_i = 7; lsu_value_i = 32'h777;
        @(posedge clk_i); #1;
        n_vec++;
        if (pending_o !== 32'd0) begin
            n_err++; $display("FAIL conflict_late_clear: got %h, want 00000000", pending_o);
        end
        @(negedge clk_i);
        drive_idle();
    endtask

    task automatic test_x0_write();
        @(negedge clk_i);
        d_valid_i = 1; d_rd_i = 3; d_long_i = 1;
        @(negedge clk_i);
        drive_idle();
        mdu_valid_i = 1; mdu_rd_i = 0; mdu_value_i = 32'h1234;
        exp_q.push_back('{rd: 5'd0, value: 32'h1234, store: 1'b0});
        #1;
        n_vec++;
        if (mdu_ready_o !== 1'b1) begin
            n_err++; $display("FAIL x0_ready: got %b, want 1", mdu_ready_o);
        end
        @(posedge clk_i); #1;
        exp = exp_q.pop_front();
        n_vec++;
        if ({rf_rd_o, rf_rd_value_o, rf_rd_store_o} !== {exp.rd, exp.value, exp.store}) begin
            n_err++;
            $display("FAIL x0_write: got rd=%0d val=%h st=%b, want rd=%0d val=%h st=%b",
                     rf_rd_o, rf_rd_value_o, rf_rd_store_o, exp.rd, exp.value, exp.store);
        end
        n_vec++;
        if (pending_o !== 32'h0000_0008) begin
            n_err++; $display("FAIL x0_pending: got %h, want 00000008", pending_o);
        end
        @(negedge clk_i);
        drive_idle();
    endtask

    task automatic test_reset_midop();
        @(negedge clk_i);
        d_valid_i = 1; d_rd_i = 9; d_long_i = 1;
        @(posedge clk_i); #1;
        n_vec++;
        if (pending_o !== 32'h0000_0208) begin
            n_err++; $display("FAIL midop_pending: got %h, want 00000208", pending_o);
        end
        @(negedge clk_i);
        drive_idle();
        rst_n_i = 0;
        lsu_valid_i = 1; lsu_rd_i = 3; mdu_valid_i = 1; mdu_rd_i = 9;
        #1;
        n_vec++;
        if ({lsu_ready_o, mdu_ready_o} !== 2'b00) begin
            n_err++;
            $display("FAIL midop_readies: got %b%b, want 00", lsu_ready_o, mdu_ready_o);
        end
        @(posedge clk_i); #1;
        n_vec++;
        if ({pending_o, rf_rd_store_o} !== 33'd0) begin
            n_err++;
            $display("FAIL midop_cleared: got pend=%h st=%b, want 0 0", pending_o, rf_rd_store_o);
        end
        @(negedge clk_i);
        drive_idle();
        rst_n_i = 1;
        d_valid_i = 1; d_rs1_i = 3;
        #1;
        n_vec++;
        if (d_stall_o !== 1'b0) begin
            n_err++; $display("FAIL midop_no_stall: got %b, want 0", d_stall_o);
        end
        @(negedge clk_i);
        drive_idle();
    endtask

    initial begin
        rst_n_i = 0;
        drive_idle();
        repeat (2) @(posedge clk_i);
        test_reset();
        test_hazard_lsu();
        test_round_robin();
        test_starvation();
        test_set_clear_conflict();
        test_x0_write();
        test_reset_midop();
        repeat (2) @(posedge clk_i);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
